lock_entry_sequencer: RTL and testbench
=======================================

Name: lock_entry_sequencer

Overview:
- Sequences a three-stage, two-digit combination entry on the board's switch pair (digit_a, digit_b) and six seven-segment displays.
- Compares the entries against a parameterised code and tracks failed attempts, with a timed lockout after too many failures.
- Drives per-display nibble/mode buses. Seven-segment decoding and active-low inversion are done downstream by the existing hex decoders.

Parameters:
- CODE0, 8'h28, expected {digit_a,digit_b} for stage 0
- CODE1, 8'h19, expected pair for stage 1
- CODE2, 8'h96, expected pair for stage 2
- MAX_FAILS, 3, failed attempts that trigger lockout (1..7)
- FAIL_CYCLES, 16, cycles the FAIL indication is held
- LOCKOUT_CYCLES, 64, cycles the lockout lasts
- TIMER_W, 16, width of the shared down-counter timer

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enter  in  1  raw pushbutton level, active-high, asynchronous to clock
- digit_a  in  4  left switch digit, BCD
- digit_b  in  4  right switch digit, BCD
- disp_nib  out  24  nibble for display n at [4n+3:4n], n=0..5
- disp_mode  out  12  mode for display n at [2n+1:2n]: 00 blank, 01 hex nibble, 10 dash, 11 unused
- unlocked  out  1  high while in UNLOCKED
- locked_out  out  1  high while in LOCKOUT
- fail_count  out  3  failed attempts since last unlock or lockout expiry
- digit_err  out  1  one-cycle pulse when enter is pressed with a non-BCD digit

Behaviour:
Reset (asynchronous, active-low):
- State ENTRY0; synchroniser, edge register, match flag, fail_count and timer all cleared.
- unlocked=0, locked_out=0, digit_err=0.
- Display outputs take the ENTRY0 pattern immediately.

Enter path:
- enter passes through a 2-flop synchroniser, then a rising-edge detector.
- enter high before clock edge k produces enter_rise during cycle k+1→k+2. Its effect is visible after edge k+2.
- Holding enter high counts as one press.

digit_err:
- On enter_rise in an ENTRY state with digit_a>9 or digit_b>9, the state and match flag are unchanged and digit_err pulses for 1 cycle.

States:
- ENTRY0:
  - On a valid enter_rise: match <= ({a,b}==CODE0); go to ENTRY1.
  - Display: d0=digit_a, d1=digit_b live (hex mode); d2–d5 blank.
- ENTRY1:
  - On a valid enter_rise: match <= match & ({a,b}==CODE1); go to ENTRY2.
  - Display: d0,d1 dash; d2=a, d3=b live; d4,d5 blank.
- ENTRY2:
  - On a valid enter_rise: match <= match & ({a,b}==CODE2); go to CHECK.
  - Display: d0–d3 dash; d4=a, d5=b live.
- CHECK (exactly 1 cycle):
  - If match=1: go to UNLOCKED and clear fail_count.
  - Else if fail_count+1 >= MAX_FAILS: go to LOCKOUT and load timer with LOCKOUT_CYCLES-1.
  - Else: go to FAIL, increment fail_count and load timer with FAIL_CYCLES-1.
  - Display: all dash.
- UNLOCKED:
  - Display: all six show nibble 1 (hex mode); unlocked=1.
  - enter_rise (digit validity ignored) returns to ENTRY0 and clears match.
- FAIL:
  - Display: all dash. The timer decrements each cycle; at timer==0 go to ENTRY0.
  - enter ignored.
- LOCKOUT:
  - Display: all dash; locked_out=1. The timer decrements; at timer==0 go to ENTRY0 and clear fail_count.
  - enter ignored.

Rules:
- Mismatches are never revealed before CHECK; all three stages are always collected.
- fail_count saturates and never exceeds MAX_FAILS-1 outside LOCKOUT.
- In blank and dash modes, disp_nib is 4'h0.
- Reset asserted mid-sequence, mid-FAIL or mid-LOCKOUT aborts everything to the reset state. A lockout cannot be survived across reset.
- No illegal state may hang: unused encodings return to ENTRY0 on the next clock.

Test Plan:
- Reset, then 28 / 19 / 96 with one clean press each → ENTRY1 and ENTRY2 patterns seen in turn, CHECK for 1 cycle, then unlocked=1 and disp_mode=12'b01_01_01_01_01_01 with all nibbles 1; enter again → ENTRY0, unlocked=0.
- 28 / 19 / 95 → FAIL for 16 cycles (all dash), fail_count=1, then back to ENTRY0.
- Three wrong sequences in a row → third CHECK enters LOCKOUT (not FAIL); locked_out=1 for 64 cycles; presses during lockout are ignored; on exit fail_count=0.
- Press enter with digit_a=4'hA in ENTRY1 → 1-cycle digit_err pulse, state stays ENTRY1; press again with 19 → ENTRY2.
- Hold enter high for 20 cycles in ENTRY0 → single advance to ENTRY1 only; measured latency from enter rise to state change is 3 edges.
- Assert reset during LOCKOUT and during ENTRY2 → immediate ENTRY0 pattern, all flags and fail_count zero; a correct sequence afterwards unlocks.

Source files
------------

// File: rtl/lock_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lock_entry_sequencer
// Purpose  : Collects a three-stage, two-digit combination from a pair of BCD
//            switch digits. Each stage is confirmed with the enter button. The
//            entries are checked against CODE0..CODE2 only after all three
//            stages are in. Failed attempts are counted, and too many of them
//            trigger a timed lockout. Per-display nibble/mode buses feed the
//            existing downstream hex decoders.
// Ports    : clock      - system clock
//            reset      - asynchronous, active-low reset
//            enter      - raw pushbutton level (async to clock)
//            digit_a/b  - left/right BCD switch digits
//            disp_nib   - nibble for display n at [4n+3:4n]
//            disp_mode  - mode for display n at [2n+1:2n]
//                         (00 blank, 01 hex, 10 dash)
//            unlocked   - high while unlocked
//            locked_out - high while locked out
//            fail_count - failed attempts since last unlock / lockout expiry
//            digit_err  - one-cycle pulse on enter with a non-BCD digit
// Revision : 1.0 - initial release
// ============================================================================
module lock_entry_sequencer #(
  parameter logic [7:0]  CODE0          = 8'h28,
  parameter logic [7:0]  CODE1          = 8'h19,
  parameter logic [7:0]  CODE2          = 8'h96,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned FAIL_CYCLES    = 16,
  parameter int unsigned LOCKOUT_CYCLES = 64,
  parameter int unsigned TIMER_W        = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enter,
  input  logic [3:0]   digit_a,
  input  logic [3:0]   digit_b,
  output logic [23:0]  disp_nib,
  output logic [11:0]  disp_mode,
  output logic         unlocked,
  output logic         locked_out,
  output logic [2:0]   fail_count,
  output logic         digit_err
);

  localparam logic [1:0] c_mode_blank = 2'b00;
  localparam logic [1:0] c_mode_hex   = 2'b01;
  localparam logic [1:0] c_mode_dash  = 2'b10;

  localparam logic [3:0]         c_max_fails  = 4'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] c_fail_load  = TIMER_W'(FAIL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_lock_load  = TIMER_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_ENTRY0   = 3'd0,
    ST_ENTRY1   = 3'd1,
    ST_ENTRY2   = 3'd2,
    ST_CHECK    = 3'd3,
    ST_UNLOCKED = 3'd4,
    ST_FAIL     = 3'd5,
    ST_LOCKOUT  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_sync2_d;
  logic                r_match;
  logic                w_match_nxt;
  logic [2:0]          r_fail_count;
  logic [2:0]          w_fail_nxt;
  logic [TIMER_W-1:0]  r_timer;
  logic [TIMER_W-1:0]  w_timer_nxt;
  logic                r_digit_err;
  logic                w_digit_err_nxt;
  logic                w_enter_rise;
  logic                w_bad_digit;
  logic [7:0]          w_pair;

  // Two-flop synchroniser plus edge register; a held button yields one rise.
  assign w_enter_rise = r_sync2 & ~r_sync2_d;
  assign w_bad_digit  = (digit_a > 4'd9) || (digit_b > 4'd9);
  assign w_pair       = {digit_a, digit_b};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync2_d    <= 1'b0;
      r_state      <= ST_ENTRY0;
      r_match      <= 1'b0;
      r_fail_count <= 3'd0;
      r_timer      <= '0;
      r_digit_err  <= 1'b0;
    end else begin
      r_sync1      <= enter;
      r_sync2      <= r_sync1;
      r_sync2_d    <= r_sync2;
      r_state      <= w_state_nxt;
      r_match      <= w_match_nxt;
      r_fail_count <= w_fail_nxt;
      r_timer      <= w_timer_nxt;
      r_digit_err  <= w_digit_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_match_nxt     = r_match;
    w_fail_nxt      = r_fail_count;
    w_timer_nxt     = r_timer;
    w_digit_err_nxt = 1'b0;
    case (r_state)
      ST_ENTRY0: begin
        if (w_enter_rise) begin
          if (w_bad_digit) begin
            w_digit_err_nxt = 1'b1;
          end else begin
            w_match_nxt = (w_pair == CODE0);
            w_state_nxt = ST_ENTRY1;
          end
        end
      end
      ST_ENTRY1: begin
        if (w_enter_rise) begin
          if (w_bad_digit) begin
            w_digit_err_nxt = 1'b1;
          end else begin
            w_match_nxt = r_match & (w_pair == CODE1);
            w_state_nxt = ST_ENTRY2;
          end
        end
      end
      ST_ENTRY2: begin
        if (w_enter_rise) begin
          if (w_bad_digit) begin
            w_digit_err_nxt = 1'b1;
          end else begin
            w_match_nxt = r_match & (w_pair == CODE2);
            w_state_nxt = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (r_match) begin
          w_state_nxt = ST_UNLOCKED;
          w_fail_nxt  = 3'd0;
        end else if (({1'b0, r_fail_count} + 4'd1) >= c_max_fails) begin
          // The attempt that reaches the limit goes straight to lockout;
          // the counter is cleared when the lockout expires.
          w_state_nxt = ST_LOCKOUT;
          w_timer_nxt = c_lock_load;
        end else begin
          w_state_nxt = ST_FAIL;
          w_fail_nxt  = r_fail_count + 3'd1;
          w_timer_nxt = c_fail_load;
        end
      end
      ST_UNLOCKED: begin
        if (w_enter_rise) begin
          w_state_nxt = ST_ENTRY0;
          w_match_nxt = 1'b0;
        end
      end
      ST_FAIL: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_ENTRY0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_ENTRY0;
          w_fail_nxt  = 3'd0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_ENTRY0;
        w_match_nxt = 1'b0;
      end
    endcase
  end

  // Display pattern is purely a function of state and the live digits, so
  // the ENTRY0 pattern appears as soon as reset is asserted.
  always_comb begin
    disp_mode = {6{c_mode_blank}};
    disp_nib  = 24'h0;
    case (r_state)
      ST_ENTRY0: begin
        disp_mode[1:0]   = c_mode_hex;
        disp_mode[3:2]   = c_mode_hex;
        disp_nib[3:0]    = digit_a;
        disp_nib[7:4]    = digit_b;
      end
      ST_ENTRY1: begin
        disp_mode[3:0]   = {2{c_mode_dash}};
        disp_mode[5:4]   = c_mode_hex;
        disp_mode[7:6]   = c_mode_hex;
        disp_nib[11:8]   = digit_a;
        disp_nib[15:12]  = digit_b;
      end
      ST_ENTRY2: begin
        disp_mode[7:0]   = {4{c_mode_dash}};
        disp_mode[9:8]   = c_mode_hex;
        disp_mode[11:10] = c_mode_hex;
        disp_nib[19:16]  = digit_a;
        disp_nib[23:20]  = digit_b;
      end
      ST_UNLOCKED: begin
        disp_mode = {6{c_mode_hex}};
        disp_nib  = {6{4'h1}};
      end
      ST_CHECK, ST_FAIL, ST_LOCKOUT: begin
        disp_mode = {6{c_mode_dash}};
      end
      default: begin
        disp_mode = {6{c_mode_blank}};
      end
    endcase
  end

  assign unlocked   = (r_state == ST_UNLOCKED);
  assign locked_out = (r_state == ST_LOCKOUT);
  assign fail_count = r_fail_count;
  assign digit_err  = r_digit_err;

endmodule
`default_nettype wire

// File: tb/tb_lock_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_entry_sequencer
// Purpose  : Self-checking bench for lock_entry_sequencer. A press-level
//            reference model predicts the display pattern, the flags and the
//            fail count from the entered digit pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_entry_sequencer;

  localparam logic [7:0] c_code0 = 8'h28;
  localparam logic [7:0] c_code1 = 8'h19;
  localparam logic [7:0] c_code2 = 8'h96;
  localparam int         c_max_fails = 3;
  localparam int         c_fail_cyc  = 16;
  localparam int         c_lock_cyc  = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enter = 1'b0;
  logic [3:0]  digit_a = 4'd0;
  logic [3:0]  digit_b = 4'd0;
  logic [23:0] disp_nib;
  logic [11:0] disp_mode;
  logic        unlocked;
  logic        locked_out;
  logic [2:0]  fail_count;
  logic        digit_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model phases: 0..2 entering stage n, 3 check, 4 unlocked, 5 fail wait,
  // 6 lockout wait.
  int         m_ph   = 0;
  int         m_fail = 0;
  logic [7:0] m_pair [3];

  lock_entry_sequencer #(
    .CODE0(c_code0), .CODE1(c_code1), .CODE2(c_code2),
    .MAX_FAILS(c_max_fails), .FAIL_CYCLES(c_fail_cyc),
    .LOCKOUT_CYCLES(c_lock_cyc), .TIMER_W(16)
  ) dut (
    .clock(clock), .reset(reset), .enter(enter),
    .digit_a(digit_a), .digit_b(digit_b),
    .disp_nib(disp_nib), .disp_mode(disp_mode),
    .unlocked(unlocked), .locked_out(locked_out),
    .fail_count(fail_count), .digit_err(digit_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {mode, nibbles}: in entry stage s, displays below 2s show dashes,
  // displays 2s and 2s+1 show the live digits, the rest are blank.
  function automatic logic [35:0] exp_disp(input int ph, input logic [3:0] a, input logic [3:0] b);
    logic [11:0] md;
    logic [23:0] nb;
    md = '0;
    nb = '0;
    for (int n = 0; n < 6; n++) begin
      if (ph <= 2) begin
        if (n < 2 * ph)           md[2*n +: 2] = 2'b10;
        else if (n == 2 * ph)     begin md[2*n +: 2] = 2'b01; nb[4*n +: 4] = a; end
        else if (n == 2 * ph + 1) begin md[2*n +: 2] = 2'b01; nb[4*n +: 4] = b; end
      end else if (ph == 4) begin
        md[2*n +: 2] = 2'b01;
        nb[4*n +: 4] = 4'h1;
      end else begin
        md[2*n +: 2] = 2'b10;
      end
    end
    return {md, nb};
  endfunction

  task automatic check_outputs(input string tag);
    logic [35:0] e;
    e = exp_disp(m_ph, digit_a, digit_b);
    chk({tag, ".mode"}, 64'(disp_mode), 64'(e[35:24]));
    chk({tag, ".nib"}, 64'(disp_nib), 64'(e[23:0]));
    chk({tag, ".unlocked"}, 64'(unlocked), 64'(m_ph == 4));
    chk({tag, ".locked_out"}, 64'(locked_out), 64'(m_ph == 6));
    if (m_ph != 6) chk({tag, ".fail_count"}, 64'(fail_count), 64'(m_fail));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    enter = 1'b0;
    #1;
    m_ph   = 0;
    m_fail = 0;
    check_outputs({tag, ".async"});
    chk({tag, ".digit_err"}, 64'(digit_err), 64'd0);
    #2;
    reset = 1'b1;
    tick();
    check_outputs({tag, ".released"});
  endtask

  // One button press, issued just after a clock edge. Effect lands on the
  // third edge after enter goes high.
  task automatic press(input string tag, input logic [3:0] a, input logic [3:0] b);
    logic bad;
    bad     = (a > 4'd9) || (b > 4'd9);
    digit_a = a;
    digit_b = b;
    enter   = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    check_outputs({tag, ".before"});
    tick();
    if (m_ph <= 2) begin
      if (!bad) begin
        m_pair[m_ph] = {a, b};
        m_ph++;
      end
      chk({tag, ".digit_err"}, 64'(digit_err), 64'(bad));
    end else if (m_ph == 4) begin
      m_ph = 0;
      chk({tag, ".digit_err"}, 64'(digit_err), 64'd0);
    end
    check_outputs({tag, ".after"});
    if (bad) begin
      tick();
      chk({tag, ".err_pulse_end"}, 64'(digit_err), 64'd0);
    end
  endtask

  // Called while in the check cycle. abort_at > 0 asserts reset that many
  // cycles into a fail/lockout wait.
  task automatic resolve(input string tag, input int abort_at);
    logic ok;
    int   n;
    int   bad_flag;
    int   exp_len;
    ok = (m_pair[0] == c_code0) && (m_pair[1] == c_code1) && (m_pair[2] == c_code2);
    tick();
    if (ok) begin
      m_ph = 4; m_fail = 0;
    end else if (m_fail + 1 >= c_max_fails) begin
      m_ph = 6;
    end else begin
      m_ph = 5; m_fail++;
    end
    check_outputs({tag, ".result"});
    if (m_ph == 5 || m_ph == 6) begin
      exp_len  = (m_ph == 6) ? c_lock_cyc : c_fail_cyc;
      n        = 1;
      bad_flag = 0;
      while (n < 300) begin
        if (n == 5) begin
          digit_a = c_code0[7:4];
          digit_b = c_code0[3:0];
          enter   = 1'b1;
        end
        if (n == 7) enter = 1'b0;
        tick();
        if (abort_at > 0 && n == abort_at) begin
          do_reset({tag, ".abort"});
          return;
        end
        if (disp_mode[1:0] != 2'b10) break;
        if (locked_out !== (m_ph == 6)) bad_flag++;
        n++;
      end
      chk({tag, ".wait_len"}, 64'(n), 64'(exp_len));
      chk({tag, ".wait_flag"}, 64'(bad_flag), 64'd0);
      if (m_ph == 6) m_fail = 0;
      m_ph = 0;
      check_outputs({tag, ".back_to_entry0"});
    end
  endtask

  task automatic attempt(input string tag, input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    press({tag, ".s0"}, p0[7:4], p0[3:0]);
    press({tag, ".s1"}, p1[7:4], p1[3:0]);
    press({tag, ".s2"}, p2[7:4], p2[3:0]);
    resolve(tag, 0);
    if (m_ph == 4) press({tag, ".relock"}, 4'd3, 4'd3);
  endtask

  function automatic logic [7:0] rnd_pair(input logic [7:0] code);
    if ($urandom_range(0, 2) == 0) return code;
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    int lat;

    // Reset state
    #12;
    check_outputs("reset");
    chk("reset.digit_err", 64'(digit_err), 64'd0);
    reset = 1'b1;
    tick();
    check_outputs("reset_release");

    // Correct code unlocks, enter relocks
    attempt("correct", c_code0, c_code1, c_code2);

    // Wrong last stage -> fail wait, count 1
    attempt("wrong_last", c_code0, c_code1, 8'h95);

    // Non-BCD digit in stage 1 is rejected without advancing
    press("bcd.s0", 4'h2, 4'h8);
    press("bcd.bad", 4'hA, 4'h9);
    press("bcd.s1", 4'h1, 4'h9);
    press("bcd.s2", 4'h9, 4'h6);
    resolve("bcd", 0);
    press("bcd.relock", 4'hF, 4'hF);

    // Three consecutive failures -> lockout on the third
    attempt("lock1", 8'h11, c_code1, c_code2);
    attempt("lock2", c_code0, 8'h00, c_code2);
    attempt("lock3", 8'h99, 8'h99, 8'h99);
    chk("lock.count_cleared", 64'(fail_count), 64'd0);

    // Held button counts once, latency three edges
    digit_a = 4'h2;
    digit_b = 4'h8;
    enter   = 1'b1;
    lat     = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (lat == 0 && disp_mode[1:0] == 2'b10) lat = i + 1;
    end
    chk("hold.latency", 64'(lat), 64'd3);
    m_pair[0] = 8'h28;
    m_ph      = 1;
    check_outputs("hold.single_advance");
    enter = 1'b0;
    tick();
    tick();
    press("hold.s1", 4'h1, 4'h9);
    press("hold.s2", 4'h9, 4'h6);
    resolve("hold", 0);
    press("hold.relock", 4'h0, 4'h0);

    // Reset during lockout
    attempt("rl1", 8'h01, 8'h02, 8'h03);
    attempt("rl2", 8'h04, 8'h05, 8'h06);
    press("rl3.s0", 4'h0, 4'h7);
    press("rl3.s1", 4'h0, 4'h8);
    press("rl3.s2", 4'h0, 4'h9);
    resolve("rl3", 20);

    // Reset during stage 2, then a correct sequence unlocks
    press("re2.s0", 4'h2, 4'h8);
    press("re2.s1", 4'h1, 4'h9);
    do_reset("re2");
    attempt("after_reset", c_code0, c_code1, c_code2);

    // Randomised attempts with occasional non-BCD presses
    for (int t = 0; t < 10; t++) begin
      logic [7:0] p [3];
      p[0] = rnd_pair(c_code0);
      p[1] = rnd_pair(c_code1);
      p[2] = rnd_pair(c_code2);
      for (int s = 0; s < 3; s++) begin
        if ($urandom_range(0, 3) == 0)
          press("rnd.bad", 4'($urandom_range(10, 15)), 4'($urandom_range(0, 15)));
        press("rnd.stage", p[s][7:4], p[s][3:0]);
      end
      resolve("rnd", 0);
      if (m_ph == 4) press("rnd.relock", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
